// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-style control unit: sequences fetch/decode/execute/memory/
// writeback one state per cycle and Moore-decodes the datapath controls.
// Adds a memory-ready handshake, BNE, JAL, an illegal-opcode trap and a
// one-cycle retire pulse in the last state of every instruction.
module mc_control_fsm #(
    parameter int unsigned OP_W     = 6,
    parameter int unsigned STATE_W  = 4,
    parameter int unsigned WAIT_MEM = 1,
    parameter int unsigned TRAP_EN  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               branch_ne,
    output logic [1:0]         pc_source,
    output logic               mem_read,
    output logic               mem_write,
    output logic               iord,
    output logic               ir_write,
    output logic [1:0]         mem_to_reg,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic               trap,
    output logic               retire,
    output logic [STATE_W-1:0] state
);

    localparam int unsigned ST_W  = 4;
    localparam int unsigned OPC_W = 6;

    localparam logic WAIT_B = (WAIT_MEM != 0);
    localparam logic TRAP_B = (TRAP_EN != 0);

    localparam logic [OPC_W-1:0] OP_R    = 6'b000000;
    localparam logic [OPC_W-1:0] OP_LW   = 6'b001000;
    localparam logic [OPC_W-1:0] OP_SW   = 6'b010000;
    localparam logic [OPC_W-1:0] OP_ADDI = 6'b000010;
    localparam logic [OPC_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OPC_W-1:0] OP_BNE  = 6'b000101;
    localparam logic [OPC_W-1:0] OP_J    = 6'b100000;
    localparam logic [OPC_W-1:0] OP_JAL  = 6'b100001;

    typedef enum logic [ST_W-1:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_IEXEC  = 4'd11,
        S_IWB    = 4'd12,
        S_TRAP   = 4'd13
    } state_e;

    state_e state_q;
    state_e state_d;

    logic [OPC_W-1:0] op_lo;
    logic             op_hi_zero;
    logic             is_r;
    logic             is_lw;
    logic             is_sw;
    logic             is_addi;
    logic             is_beq;
    logic             is_bne;
    logic             is_j;
    logic             is_jal;
    logic             is_legal;
    logic             rdy;

    // Opcode classification; any nonzero bit above [5:0] makes it illegal
    always_comb begin
        op_lo      = opcode[OPC_W-1:0];
        op_hi_zero = ((opcode >> OPC_W) == '0);
        is_r       = op_hi_zero && (op_lo == OP_R);
        is_lw      = op_hi_zero && (op_lo == OP_LW);
        is_sw      = op_hi_zero && (op_lo == OP_SW);
        is_addi    = op_hi_zero && (op_lo == OP_ADDI);
        is_beq     = op_hi_zero && (op_lo == OP_BEQ);
        is_bne     = op_hi_zero && (op_lo == OP_BNE);
        is_j       = op_hi_zero && (op_lo == OP_J);
        is_jal     = op_hi_zero && (op_lo == OP_JAL);
        is_legal   = is_r | is_lw | is_sw | is_addi | is_beq | is_bne | is_j | is_jal;
        rdy        = mem_ready | ~WAIT_B;
    end

    // State register with synchronous active-high reset to IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (rdy) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_r) begin
                    state_d = S_EXEC;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEMADR;
                end else if (is_addi) begin
                    state_d = S_IEXEC;
                end else if (is_beq || is_bne) begin
                    state_d = S_BRANCH;
                end else if (is_j || is_jal) begin
                    state_d = S_JUMP;
                end else if (TRAP_B) begin
                    state_d = S_TRAP;
                end else begin
                    state_d = S_FETCH;
                end
            end
            // Anything other than a store proceeds as a load
            S_MEMADR: state_d = is_sw ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (rdy) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR: begin
                if (rdy) begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_TRAP:   state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore output decode; everything defaults to 0
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_source     = 2'b00;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 2'b00;
        reg_write     = 1'b0;
        reg_dst       = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        trap          = 1'b0;
        retire        = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = 2'b00;
                // PC/IR update only on the ready cycle so PC advances once
                ir_write  = rdy;
                pc_write  = rdy;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = 2'b00;
                // An illegal opcode retiring as a NOP ends here
                retire    = ~is_legal & ~TRAP_B;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b00;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                reg_dst    = 2'b00;
                retire     = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                retire    = rdy;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
                alu_op    = 2'b10;
            end
            S_RWB: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b01;
                mem_to_reg = 2'b00;
                retire     = 1'b1;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b00;
            end
            S_IWB: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b00;
                mem_to_reg = 2'b00;
                retire     = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = 2'b00;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                branch_ne     = op_lo[0];
                retire        = 1'b1;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                retire    = 1'b1;
                // JAL links the already-incremented PC into r31
                if (is_jal) begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                end
            end
            S_TRAP: begin
                trap      = 1'b1;
                pc_write  = 1'b1;
                pc_source = 2'b11;
            end
            default: begin
            end
        endcase
    end

    // State observation port, zero-extended
    always_comb begin
        state = STATE_W'(state_q);
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm with hand-computed expectations.
module tb_mc_control_fsm;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b001000;
    localparam logic [5:0] OP_SW   = 6'b010000;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b100000;
    localparam logic [5:0] OP_JAL  = 6'b100001;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       trap;
    logic       retire;
    logic [3:0] state;
    logic [20:0] outs;

    int nvec;
    int nerr;

    mc_control_fsm #(
        .OP_W(6), .STATE_W(4), .WAIT_MEM(1), .TRAP_EN(1)
    ) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .pc_source(pc_source), .mem_read(mem_read), .mem_write(mem_write),
        .iord(iord), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .reg_dst(reg_dst), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .trap(trap), .retire(retire),
        .state(state)
    );

    assign outs = {pc_write, pc_write_cond, branch_ne, pc_source, mem_read,
                   mem_write, iord, ir_write, mem_to_reg, reg_write, reg_dst,
                   alu_src_a, alu_src_b, alu_op, trap, retire};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then apply the inputs for the newly entered state
    task automatic cyc(input logic [5:0] op, input logic rdy);
        @(posedge clk);
        #2;
        opcode    = op;
        mem_ready = rdy;
        #1;
    endtask

    initial begin
        nvec      = 0;
        nerr      = 0;
        reset     = 1'b1;
        opcode    = OP_R;
        mem_ready = 1'b1;

        // Reset held for three edges
        cyc(OP_LW, 1'b1);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_outs", 32'(outs), 32'd0);
        cyc(OP_LW, 1'b1);
        cyc(OP_LW, 1'b1);
        reset = 1'b0;
        #1;
        chk("rel_state", 32'(state), 32'd0);
        chk("rel_outs", 32'(outs), 32'd0);

        // LW with memory always ready
        cyc(OP_LW, 1'b1);
        chk("lw_fetch_st", 32'(state), 32'd1);
        chk("lw_fetch_mrd", 32'(mem_read), 32'd1);
        chk("lw_fetch_pcw", 32'(pc_write), 32'd1);
        chk("lw_fetch_alub", 32'(alu_src_b), 32'd1);
        cyc(OP_LW, 1'b1);
        chk("lw_dec_st", 32'(state), 32'd2);
        chk("lw_dec_alub", 32'(alu_src_b), 32'd3);
        cyc(OP_LW, 1'b1);
        chk("lw_madr_st", 32'(state), 32'd3);
        chk("lw_madr_alu", 32'({alu_src_a, alu_src_b, alu_op}), 32'b1_10_00);
        cyc(OP_LW, 1'b1);
        chk("lw_mrd_st", 32'(state), 32'd4);
        chk("lw_mrd_iord", 32'({mem_read, iord}), 32'b11);
        cyc(OP_LW, 1'b1);
        chk("lw_mwb_st", 32'(state), 32'd5);
        chk("lw_mwb_ctl", 32'({reg_write, mem_to_reg, reg_dst, retire}), 32'b1_01_00_1);

        // FETCH stalled three cycles on memory
        cyc(OP_SW, 1'b0);
        chk("stall0_st", 32'(state), 32'd1);
        chk("stall0_pw", 32'({pc_write, ir_write, mem_read}), 32'b001);
        cyc(OP_SW, 1'b0);
        chk("stall1_pw", 32'({pc_write, ir_write, state}), 32'b00_0001);
        cyc(OP_SW, 1'b0);
        chk("stall2_pw", 32'({pc_write, ir_write, state}), 32'b00_0001);
        cyc(OP_SW, 1'b1);
        chk("stall_rdy_pw", 32'({pc_write, ir_write, state}), 32'b11_0001);

        // SW with two wait cycles in MEMWR
        cyc(OP_SW, 1'b1);
        chk("sw_dec_st", 32'(state), 32'd2);
        cyc(OP_SW, 1'b1);
        chk("sw_madr_st", 32'(state), 32'd3);
        cyc(OP_SW, 1'b0);
        chk("sw_wr0", 32'({state, mem_write, iord, retire}), 32'b0110_1_1_0);
        cyc(OP_SW, 1'b0);
        chk("sw_wr1", 32'({state, mem_write, iord, retire}), 32'b0110_1_1_0);
        cyc(OP_SW, 1'b1);
        chk("sw_wr2", 32'({state, mem_write, iord, retire}), 32'b0110_1_1_1);

        // JAL
        cyc(OP_JAL, 1'b1);
        chk("jal_fetch_st", 32'(state), 32'd1);
        cyc(OP_JAL, 1'b1);
        chk("jal_dec_st", 32'(state), 32'd2);
        cyc(OP_JAL, 1'b1);
        chk("jal_jump_st", 32'(state), 32'd10);
        chk("jal_ctl", 32'({pc_write, pc_source, reg_write, reg_dst, mem_to_reg, retire}),
            32'b1_10_1_10_10_1);

        // Plain J does not link
        cyc(OP_J, 1'b1);
        cyc(OP_J, 1'b1);
        cyc(OP_J, 1'b1);
        chk("j_jump_st", 32'(state), 32'd10);
        chk("j_ctl", 32'({pc_write, pc_source, reg_write, reg_dst, mem_to_reg, retire}),
            32'b1_10_0_00_00_1);

        // BNE
        cyc(OP_BNE, 1'b1);
        cyc(OP_BNE, 1'b1);
        cyc(OP_BNE, 1'b1);
        chk("bne_st", 32'(state), 32'd9);
        chk("bne_ctl", 32'({branch_ne, pc_write_cond, pc_source, alu_op, alu_src_a, pc_write}),
            32'b1_1_01_01_1_0);

        // ADDI
        cyc(OP_ADDI, 1'b1);
        cyc(OP_ADDI, 1'b1);
        cyc(OP_ADDI, 1'b1);
        chk("addi_iexec_st", 32'(state), 32'd11);
        cyc(OP_ADDI, 1'b1);
        chk("addi_iwb", 32'({state, reg_write, reg_dst, retire}), 32'b1100_1_00_1);

        // Illegal opcode traps, then refetches
        cyc(OP_BAD, 1'b1);
        cyc(OP_BAD, 1'b1);
        cyc(OP_BAD, 1'b1);
        chk("trap_st", 32'(state), 32'd13);
        chk("trap_ctl", 32'({trap, pc_write, pc_source, retire}), 32'b1_1_11_0);
        cyc(OP_R, 1'b1);
        chk("trap_next_st", 32'(state), 32'd1);

        // R-type interrupted by reset in EXEC
        cyc(OP_R, 1'b1);
        cyc(OP_R, 1'b1);
        chk("r_exec_st", 32'(state), 32'd7);
        chk("r_exec_ctl", 32'({alu_src_a, alu_src_b, alu_op, reg_write}), 32'b1_00_10_0);
        reset = 1'b1;
        cyc(OP_R, 1'b1);
        chk("mid_rst_st", 32'(state), 32'd0);
        chk("mid_rst_rw", 32'(reg_write), 32'd0);
        chk("mid_rst_outs", 32'(outs), 32'd0);
        reset = 1'b0;
        cyc(OP_R, 1'b1);
        chk("post_rst_st", 32'(state), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
